// File: rtl/movz_wb_stage.sv
// movz_wb_stage: MEM/WB pipeline register with movz conditional write-back,
// GRF write port, W-stage forwarding bus and a retired-instruction counter.
`default_nettype none

module movz_wb_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_w,
  input  logic              flush_w,
  input  logic              m_valid,
  input  logic              m_regwrite,
  input  logic              m_is_movz,
  input  logic [1:0]        m_wsel,
  input  logic [4:0]        m_waddr,
  input  logic [DATA_W-1:0] m_alu,
  input  logic [DATA_W-1:0] m_dm,
  input  logic [DATA_W-1:0] m_pc,
  input  logic [DATA_W-1:0] m_rs_val,
  input  logic [DATA_W-1:0] m_rt_val,
  output logic              grf_we,
  output logic [4:0]        grf_addr,
  output logic [DATA_W-1:0] grf_wdata,
  output logic [DATA_W-1:0] w_pc,
  output logic [4:0]        fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam logic [1:0] c_WSEL_ALU = 2'd0;
  localparam logic [1:0] c_WSEL_DM  = 2'd1;
  localparam logic [1:0] c_WSEL_PC8 = 2'd2;
  localparam logic [1:0] c_WSEL_RS  = 2'd3;

  logic              r_valid;
  logic              r_regwrite;
  logic              r_is_movz;
  logic              r_rt_zero;
  logic [4:0]        r_waddr;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_retire_cnt;

  logic              w_rt_zero_m;
  logic [DATA_W-1:0] w_wdata_m;
  logic              w_load;
  logic              w_we;

  // Write data and the movz condition are resolved in M so W only holds flags.
  assign w_rt_zero_m = (m_rt_val == '0);

  always_comb begin
    w_wdata_m = m_alu;
    case (m_wsel)
      c_WSEL_ALU: w_wdata_m = m_alu;
      c_WSEL_DM:  w_wdata_m = m_dm;
      c_WSEL_PC8: w_wdata_m = m_pc + DATA_W'(8);
      c_WSEL_RS:  w_wdata_m = m_rs_val;
      default:    w_wdata_m = m_alu;
    endcase
  end

  assign w_load = ~flush_w & ~stall_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_regwrite   <= 1'b0;
      r_is_movz    <= 1'b0;
      r_rt_zero    <= 1'b0;
      r_waddr      <= '0;
      r_pc         <= '0;
      r_wdata      <= '0;
      r_retire_cnt <= '0;
    end else if (flush_w) begin
      r_valid      <= 1'b0;
      r_regwrite   <= 1'b0;
      r_is_movz    <= 1'b0;
      r_rt_zero    <= 1'b0;
      r_waddr      <= '0;
      r_pc         <= '0;
      r_wdata      <= '0;
    end else if (w_load) begin
      r_valid      <= m_valid;
      r_regwrite   <= m_regwrite;
      r_is_movz    <= m_is_movz;
      r_rt_zero    <= w_rt_zero_m;
      r_waddr      <= m_waddr;
      r_pc         <= m_pc;
      r_wdata      <= w_wdata_m;
      if (m_valid) begin
        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      end
    end
  end

  // A movz whose rt is nonzero still retires but must neither write nor forward.
  assign w_we = r_valid & r_regwrite & (r_waddr != 5'd0) & (~r_is_movz | r_rt_zero);

  assign grf_we     = w_we;
  assign grf_addr   = r_waddr;
  assign grf_wdata  = r_wdata;
  assign w_pc       = r_pc;
  assign fwd_addr   = w_we ? r_waddr : 5'd0;
  assign fwd_data   = r_wdata;
  assign retire_cnt = r_retire_cnt;

endmodule

`default_nettype wire
